// File: rtl/quad_pkg.sv
// quad_pkg: shared types and the quadrature step
// classifier used by every encoder channel.
package quad_pkg;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_CW,
    STEP_CCW,
    STEP_ILL
  } step_t;

  // Classify a move between two accepted {a,b} levels.
  function automatic step_t quad_step(
    logic [1:0] prev,
    logic [1:0] cur
  );
    step_t s;
    unique case ({prev, cur})
      4'b00_10,
      4'b10_11,
      4'b11_01,
      4'b01_00: s = STEP_CW;
      4'b00_01,
      4'b01_11,
      4'b11_10,
      4'b10_00: s = STEP_CCW;
      4'b00_11,
      4'b11_00,
      4'b01_10,
      4'b10_01: s = STEP_ILL;
      default:  s = STEP_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/quad_channel.sv
// quad_channel: one encoder channel -- synchroniser,
// glitch filter, step decode, counter, sticky error.
module quad_channel
  import quad_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int FILT_LEN = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  input  logic             err_clr,
  output logic             cw,
  output logic             ccw,
  output logic [CNT_W-1:0] pos,
  output logic             err
);

  localparam int FW = $clog2(FILT_LEN + 1);

  logic [1:0]    s1;
  logic [1:0]    s2;
  logic [1:0]    filt;
  logic [1:0]    cand;
  logic [1:0]    cand_n;
  logic [FW-1:0] fcnt;
  logic [FW-1:0] fcnt_n;
  logic [FW-1:0] cnt_nx;
  logic          primed;
  logic          acc;
  step_t         step;
  logic          cw_n;
  logic          ccw_n;
  logic          ill_n;

  // Two-flop synchroniser for the raw {a,b} pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
    end else begin
      s1 <= {a, b};
      s2 <= s1;
    end
  end

  // Filter next state; until primed every sample counts,
  // so a level held since reset is accepted silently.
  always_comb begin
    cand_n = cand;
    fcnt_n = fcnt;
    cnt_nx = fcnt;
    acc    = 1'b0;
    if (primed && (s2 == filt)) begin
      fcnt_n = '0;
    end else begin
      if (s2 == cand) begin
        cnt_nx = fcnt + FW'(1);
      end else begin
        cand_n = s2;
        cnt_nx = FW'(1);
      end
      if (cnt_nx == FW'(FILT_LEN)) begin
        acc    = 1'b1;
        fcnt_n = '0;
      end else begin
        fcnt_n = cnt_nx;
      end
    end
  end

  // Filter state registers and priming flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt   <= 2'b00;
      cand   <= 2'b00;
      fcnt   <= '0;
      primed <= 1'b0;
    end else begin
      cand <= cand_n;
      fcnt <= fcnt_n;
      if (acc) begin
        filt   <= cand_n;
        primed <= 1'b1;
      end
    end
  end

  // Step decode on a primed acceptance.
  always_comb begin
    step  = STEP_NONE;
    cw_n  = 1'b0;
    ccw_n = 1'b0;
    ill_n = 1'b0;
    if (acc && primed) begin
      step = quad_step(filt, cand_n);
    end
    unique case (step)
      STEP_CW:  cw_n  = 1'b1;
      STEP_CCW: ccw_n = 1'b1;
      STEP_ILL: ill_n = 1'b1;
      default:  ;
    endcase
  end

  // Step pulses, wrapping position and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cw  <= 1'b0;
      ccw <= 1'b0;
      pos <= '0;
      err <= 1'b0;
    end else begin
      cw  <= cw_n;
      ccw <= ccw_n;
      if (clr) begin
        pos <= '0;
      end else if (cw_n) begin
        pos <= pos + CNT_W'(1);
      end else if (ccw_n) begin
        pos <= pos - CNT_W'(1);
      end
      err <= ill_n | (err & ~err_clr);
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: N_CH independent quadrature channels,
// ports flattened per channel.
module quad_decoder #(
  parameter int N_CH     = 2,
  parameter int CNT_W    = 16,
  parameter int FILT_LEN = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_CH-1:0]       a,
  input  logic [N_CH-1:0]       b,
  input  logic [N_CH-1:0]       clr,
  input  logic [N_CH-1:0]       err_clr,
  output logic [N_CH-1:0]       cw,
  output logic [N_CH-1:0]       ccw,
  output logic [N_CH*CNT_W-1:0] pos,
  output logic [N_CH-1:0]       err
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    quad_channel #(
      .CNT_W   (CNT_W),
      .FILT_LEN(FILT_LEN)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .a      (a[i]),
      .b      (b[i]),
      .clr    (clr[i]),
      .err_clr(err_clr[i]),
      .cw     (cw[i]),
      .ccw    (ccw[i]),
      .pos    (pos[i*CNT_W +: CNT_W]),
      .err    (err[i])
    );
  end

endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: randomized scoreboard bench for
// quad_decoder with a phase-index reference model.
module tb_quad_decoder;

  localparam int N_CH     = 2;
  localparam int CNT_W    = 8;
  localparam int FILT_LEN = 4;
  localparam int LAT      = FILT_LEN + 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  a = '0;
  logic [1:0]  b = '0;
  logic [1:0]  clr = '0;
  logic [1:0]  err_clr = '0;
  logic [1:0]  cw;
  logic [1:0]  ccw;
  logic [15:0] pos;
  logic [1:0]  err;

  quad_decoder #(
    .N_CH    (N_CH),
    .CNT_W   (CNT_W),
    .FILT_LEN(FILT_LEN)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .a      (a),
    .b      (b),
    .clr    (clr),
    .err_clr(err_clr),
    .cw     (cw),
    .ccw    (ccw),
    .pos    (pos),
    .err    (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         ch;
    int         cyc;
    logic [2:0] kind;
    logic [7:0] pos;
  } ev_t;

  ev_t evq[$];

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] m_prev[2];
  bit         m_primed[2];
  logic [7:0] m_pos[2];
  bit         m_err[2];

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int idx_of(logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] phase_val(int i);
    case (i % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic int find_ev(int ch);
    for (int i = 0; i < evq.size(); i++)
      if (evq[i].ch == ch) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      m_prev[c]   = 2'b00;
      m_primed[c] = 1'b0;
      m_pos[c]    = 8'd0;
      m_err[c]    = 1'b0;
    end
  endfunction

  // Reference: steps are distance around the 4-phase
  // cycle 00,10,11,01 (+1 cw, -1 ccw, 2 illegal).
  task automatic model_accept(input int ch, input logic [1:0] v,
                              input int k, input bit c,
                              input bit ec);
    int d;
    logic [2:0] kind;
    kind = 3'b000;
    d = 0;
    if (!m_primed[ch]) begin
      m_primed[ch] = 1'b1;
    end else begin
      d = (idx_of(v) - idx_of(m_prev[ch]) + 4) % 4;
    end
    m_prev[ch] = v;
    if (d == 1) begin
      m_pos[ch] = m_pos[ch] + 8'd1;
      kind = 3'b001;
    end else if (d == 3) begin
      m_pos[ch] = m_pos[ch] - 8'd1;
      kind = 3'b010;
    end else if (d == 2 && !m_err[ch]) begin
      kind = 3'b100;
    end
    if (c) m_pos[ch] = 8'd0;
    if (d == 2) m_err[ch] = 1'b1;
    else if (ec) m_err[ch] = 1'b0;
    if (kind != 3'b000)
      evq.push_back('{ch, k + LAT, kind, m_pos[ch]});
  endtask

  task automatic end_check();
    for (int c = 0; c < 2; c++) begin
      check($sformatf("pos%0d", c), int'(pos[c*8 +: 8]),
            int'(m_pos[c]));
      check($sformatf("err%0d", c), int'(err[c]), int'(m_err[c]));
    end
  endtask

  // Hold {v0,v1} for len cycles; masks hit the accept edge.
  task automatic apply(input logic [1:0] v0, input logic [1:0] v1,
                       input int len, input logic [1:0] cm,
                       input logic [1:0] em);
    int k;
    @(negedge clk);
    {a[0], b[0]} = v0;
    {a[1], b[1]} = v1;
    k = cyc;
    model_accept(0, v0, k, cm[0], em[0]);
    model_accept(1, v1, k, cm[1], em[1]);
    for (int i = 1; i < len; i++) begin
      @(negedge clk);
      if (i == FILT_LEN + 1) begin
        clr     = cm;
        err_clr = em;
      end else begin
        clr     = '0;
        err_clr = '0;
      end
    end
    clr     = '0;
    err_clr = '0;
    end_check();
  endtask

  task automatic glitch(input int ch, input logic [1:0] gv,
                        input int gl);
    @(negedge clk);
    {a[ch], b[ch]} = gv;
    repeat (gl) @(negedge clk);
    {a[ch], b[ch]} = m_prev[ch];
    repeat (8) @(negedge clk);
    end_check();
  endtask

  task automatic step0(input int dir, input logic [1:0] cm);
    apply(phase_val(idx_of(m_prev[0]) + dir), m_prev[1], 8,
          cm, 2'b00);
  endtask

  // Monitor: pop expected events when the DUT shows one.
  logic [1:0] err_q = '0;
  always @(negedge clk) begin
    logic [2:0] obs;
    int f;
    if (reset_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        obs = {err[ch] & ~err_q[ch], ccw[ch], cw[ch]};
        f = find_ev(ch);
        while (f >= 0 && evq[f].cyc < cyc) begin
          check($sformatf("missing event ch%0d", ch), 0,
                int'(evq[f].kind));
          evq.delete(f);
          f = find_ev(ch);
        end
        if (obs != 3'b000) begin
          if (f < 0) begin
            check($sformatf("unexpected event ch%0d", ch),
                  int'(obs), 0);
          end else begin
            check($sformatf("event cycle ch%0d", ch), cyc,
                  evq[f].cyc);
            check($sformatf("event kind ch%0d", ch), int'(obs),
                  int'(evq[f].kind));
            check($sformatf("event pos ch%0d", ch),
                  int'(pos[ch*8 +: 8]), int'(evq[f].pos));
            evq.delete(f);
          end
        end
      end
    end
    err_q = err;
  end

  initial begin
    logic [1:0] v0;
    logic [1:0] v1;
    logic [1:0] cm;
    logic [1:0] em;
    int ch;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset pos", int'(pos), 0);
    check("reset pulses", int'({cw, ccw}), 0);
    check("reset err", int'(err), 0);
    reset_n = 1'b1;

    apply(2'b00, 2'b00, 10, 2'b00, 2'b00);
    for (int i = 0; i < 4; i++) step0(1, 2'b00);
    for (int i = 1; i <= 4; i++)
      apply(2'b00, phase_val(4 - i), 8, 2'b00, 2'b00);

    glitch(0, 2'b10, 3);
    step0(1, 2'b00);

    while (m_pos[0] != 8'd127) step0(1, 2'b00);
    step0(1, 2'b00);
    check("wrap up", int'(pos[7:0]), 128);
    step0(-1 + 4, 2'b00);
    check("wrap down", int'(pos[7:0]), 127);

    apply(phase_val(idx_of(m_prev[0]) + 2), m_prev[1], 8,
          2'b00, 2'b00);
    apply(phase_val(idx_of(m_prev[0]) + 2), m_prev[1], 8,
          2'b00, 2'b01);
    check("err set wins", int'(err[0]), 1);
    apply(m_prev[0], m_prev[1], 8, 2'b00, 2'b01);
    check("err cleared", int'(err[0]), 0);

    apply(m_prev[0], m_prev[1], 8, 2'b01, 2'b00);
    for (int i = 0; i < 5; i++) step0(1, 2'b00);
    step0(1, 2'b01);
    check("clr wins", int'(pos[7:0]), 0);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        ch = int'($urandom_range(0, 1));
        v0 = phase_val(idx_of(m_prev[ch]) +
                       int'($urandom_range(1, 3)));
        glitch(ch, v0, int'($urandom_range(1, FILT_LEN - 1)));
      end else begin
        v0 = 2'($urandom_range(0, 3));
        v1 = 2'($urandom_range(0, 3));
        cm = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
        em = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
        apply(v0, v1, int'($urandom_range(8, 11)), cm, em);
      end
    end

    apply(m_prev[0], phase_val(idx_of(m_prev[1]) + 2), 8,
          2'b00, 2'b00);
    step0(1, 2'b00);
    @(negedge clk);
    {a[0], b[0]} = phase_val(idx_of(m_prev[0]) + 1);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async rst pos", int'(pos), 0);
    check("async rst pulses", int'({cw, ccw}), 0);
    check("async rst err", int'(err), 0);
    evq.delete();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    apply(2'b10, 2'b01, 10, 2'b00, 2'b00);
    apply(2'b11, 2'b11, 8, 2'b00, 2'b00);

    repeat (10) @(negedge clk);
    check("pending events", evq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
